// File: rtl/operand_fetch_stage_pkg.sv
// Shared core constants and the EX-stage payload for the operand fetch stage.
package operand_fetch_stage_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned XLEN      = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      inst;
        logic [XLEN-1:0]      rs1_val;
        logic [XLEN-1:0]      rs2_val;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_we;
        logic                 is_load;
    } ex_payload_t;

    // x0 never matches a producer: it is hardwired to zero.
    function automatic logic reg_match(input logic [REG_IDX_W-1:0] src,
                                       input logic [REG_IDX_W-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/operand_fetch_stage_fwd_sel.sv
// Single-source operand selector (zero / EX bypass / WB bypass / register file).
// Bypass paths exist only when FORWARDING_EN is defined.
module operand_fetch_stage_fwd_sel
    import operand_fetch_stage_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs_idx,
    input  logic [XLEN-1:0]      rf_data,
    input  logic                 ex_fwd_en,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [XLEN-1:0]      ex_result,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic [XLEN-1:0]      operand_c
);

`ifdef FORWARDING_EN
    always_comb begin
        operand_c = rf_data;
        if (rs_idx == '0) begin
            operand_c = '0;
        end else if (ex_fwd_en && (ex_rd == rs_idx)) begin
            operand_c = ex_result;
        end else if (wb_we && (wb_rd == rs_idx)) begin
            operand_c = wb_data;
        end
    end
`else
    // Without bypassing, dependences are resolved by stalling upstream.
    logic unused_fwd_c;
    assign unused_fwd_c = ^{ex_fwd_en, ex_rd, ex_result, wb_we, wb_rd, wb_data};

    assign operand_c = (rs_idx == '0) ? '0 : rf_data;
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: resolves source operands and registers them toward EX.
// FORWARDING_EN selects bypassing with load-use stalls; otherwise stall on any RAW.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [XLEN-1:0]      id_inst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_reg_we,
    input  logic                 id_is_load,
    output logic [REG_IDX_W-1:0] rf_ra1,
    output logic [REG_IDX_W-1:0] rf_ra2,
    input  logic [XLEN-1:0]      rf_rd1,
    input  logic [XLEN-1:0]      rf_rd2,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_inst,
    output logic [XLEN-1:0]      ex_rs1_val,
    output logic [XLEN-1:0]      ex_rs2_val,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic                 ex_reg_we,
    output logic                 ex_is_load,
    input  logic [XLEN-1:0]      ex_result,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush,
    output logic [XLEN-1:0]      hazard_cnt
);

    logic            ex_valid_q, ex_valid_d;
    ex_payload_t     ex_q, ex_d;
    logic [XLEN-1:0] hazard_cnt_q, hazard_cnt_d;
    logic [XLEN-1:0] rs1_val_c, rs2_val_c;
    logic            ex_fwd_en_c, hazard_c, advance_c;

    assign rf_ra1      = id_rs1;
    assign rf_ra2      = id_rs2;
    assign ex_fwd_en_c = ex_valid_q & ex_q.reg_we & ~ex_q.is_load;
    assign advance_c   = ~ex_valid_q | ex_ready;

`ifdef FORWARDING_EN
    // Only a load in EX cannot be bypassed; its data arrives via WB next cycle.
    assign hazard_c = ex_valid_q & ex_q.is_load & ex_q.reg_we
                    & (reg_match(id_rs1, ex_q.rd) | reg_match(id_rs2, ex_q.rd));
`else
    assign hazard_c = (ex_valid_q & ex_q.reg_we
                       & (reg_match(id_rs1, ex_q.rd) | reg_match(id_rs2, ex_q.rd)))
                    | (wb_we & (reg_match(id_rs1, wb_rd) | reg_match(id_rs2, wb_rd)));
`endif

    assign id_ready = advance_c & ~hazard_c & ~flush & ~rst;

    operand_fetch_stage_fwd_sel u_fwd_sel_rs1 (
        .rs_idx    (id_rs1),
        .rf_data   (rf_rd1),
        .ex_fwd_en (ex_fwd_en_c),
        .ex_rd     (ex_q.rd),
        .ex_result (ex_result),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .operand_c (rs1_val_c)
    );

    operand_fetch_stage_fwd_sel u_fwd_sel_rs2 (
        .rs_idx    (id_rs2),
        .rf_data   (rf_rd2),
        .ex_fwd_en (ex_fwd_en_c),
        .ex_rd     (ex_q.rd),
        .ex_result (ex_result),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .operand_c (rs2_val_c)
    );

    // Next-state: flush kills, otherwise advance issues or inserts a bubble.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_d         = ex_q;
        hazard_cnt_d = hazard_cnt_q;
        if (id_valid && hazard_c && !flush && (hazard_cnt_q != '1)) begin
            hazard_cnt_d = hazard_cnt_q + XLEN'(1);
        end
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (advance_c) begin
            if (id_valid && !hazard_c) begin
                ex_valid_d   = 1'b1;
                ex_d.pc      = id_pc;
                ex_d.inst    = id_inst;
                ex_d.rs1_val = rs1_val_c;
                ex_d.rs2_val = rs2_val_c;
                ex_d.rd      = id_rd;
                ex_d.reg_we  = id_reg_we;
                ex_d.is_load = id_is_load;
            end else begin
                ex_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_q         <= '0;
            hazard_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_q         <= ex_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_q.pc;
    assign ex_inst    = ex_q.inst;
    assign ex_rs1_val = ex_q.rs1_val;
    assign ex_rs2_val = ex_q.rs2_val;
    assign ex_rd      = ex_q.rd;
    assign ex_reg_we  = ex_q.reg_we;
    assign ex_is_load = ex_q.is_load;
    assign hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus random traffic vs a reference model.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_inst;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_we, id_is_load;
    logic [4:0]  rf_ra1, rf_ra2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_inst, ex_rs1_val, ex_rs2_val;
    logic [4:0]  ex_rd;
    logic        ex_reg_we, ex_is_load;
    logic [31:0] ex_result;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic [31:0] hazard_cnt;

    logic [31:0] regs [32];
    int n_total = 0;
    int n_bad   = 0;

    // Reference model of what EX should hold.
    bit          m_valid, m_we, m_ld;
    logic [31:0] m_pc, m_inst, m_rs1, m_rs2, m_cnt;
    logic [4:0]  m_rd;

    always #5 clk = ~clk;

    assign rf_rd1 = regs[rf_ra1];
    assign rf_rd2 = regs[rf_ra2];

    operand_fetch_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_inst(id_inst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_we(id_reg_we), .id_is_load(id_is_load),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
        .ex_result(ex_result),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .hazard_cnt(hazard_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // A source depends on a producer only if it is nonzero and names the same register.
    function automatic bit reads(input logic [4:0] s, input logic [4:0] d);
        return (s != 5'd0) && (s == d);
    endfunction

    function automatic bit model_hazard();
        bit h = 1'b0;
`ifdef FORWARDING_EN
        if (m_valid && m_ld && m_we && (reads(id_rs1, m_rd) || reads(id_rs2, m_rd))) h = 1'b1;
`else
        if (m_valid && m_we && (reads(id_rs1, m_rd) || reads(id_rs2, m_rd))) h = 1'b1;
        if (wb_we && (reads(id_rs1, wb_rd) || reads(id_rs2, wb_rd))) h = 1'b1;
`endif
        return h;
    endfunction

    // Value the instruction should see for a source register right now.
    function automatic logic [31:0] model_operand(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef FORWARDING_EN
        if (m_valid && m_we && !m_ld && m_rd == idx) return ex_result;
        if (wb_we && wb_rd == idx) return wb_data;
`endif
        return regs[idx];
    endfunction

    // One clock: predict at negedge, compare after the rising edge.
    task automatic step();
        bit          adv, haz, n_valid;
        logic [31:0] n_pc, n_inst, n_rs1, n_rs2, n_cnt;
        logic [4:0]  n_rd;
        bit          n_we, n_ld;
        @(negedge clk);
        adv = !m_valid || ex_ready;
        haz = model_hazard();
        check_eq("id_ready", 32'(id_ready), 32'(!rst && adv && !haz && !flush));
        check_eq("rf_ra1", 32'(rf_ra1), 32'(id_rs1));
        check_eq("rf_ra2", 32'(rf_ra2), 32'(id_rs2));
        n_valid = m_valid; n_pc = m_pc; n_inst = m_inst; n_rs1 = m_rs1; n_rs2 = m_rs2;
        n_rd = m_rd; n_we = m_we; n_ld = m_ld; n_cnt = m_cnt;
        if (rst) begin
            n_valid = 0; n_pc = 0; n_inst = 0; n_rs1 = 0; n_rs2 = 0;
            n_rd = 0; n_we = 0; n_ld = 0; n_cnt = 0;
        end else begin
            if (id_valid && haz && !flush && m_cnt != 32'hFFFF_FFFF) n_cnt = m_cnt + 1;
            if (flush) n_valid = 0;
            else if (adv) begin
                if (id_valid && !haz) begin
                    n_valid = 1; n_pc = id_pc; n_inst = id_inst;
                    n_rs1 = model_operand(id_rs1); n_rs2 = model_operand(id_rs2);
                    n_rd = id_rd; n_we = id_reg_we; n_ld = id_is_load;
                end else n_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        if (wb_we && wb_rd != 5'd0) regs[wb_rd] = wb_data;
        m_valid = n_valid; m_pc = n_pc; m_inst = n_inst; m_rs1 = n_rs1; m_rs2 = n_rs2;
        m_rd = n_rd; m_we = n_we; m_ld = n_ld; m_cnt = n_cnt;
        check_eq("ex_valid", 32'(ex_valid), 32'(m_valid));
        check_eq("ex_pc", ex_pc, m_pc);
        check_eq("ex_inst", ex_inst, m_inst);
        check_eq("ex_rs1_val", ex_rs1_val, m_rs1);
        check_eq("ex_rs2_val", ex_rs2_val, m_rs2);
        check_eq("ex_rd", 32'(ex_rd), 32'(m_rd));
        check_eq("ex_reg_we", 32'(ex_reg_we), 32'(m_we));
        check_eq("ex_is_load", 32'(ex_is_load), 32'(m_ld));
        check_eq("hazard_cnt", hazard_cnt, m_cnt);
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input bit ld);
        id_valid = 1; id_pc = pc; id_inst = {pc[15:0], 16'h0013};
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_reg_we = 1; id_is_load = ld;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_inst = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_reg_we = 0; id_is_load = 0; ex_ready = 1; ex_result = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        step();
        check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
        check_eq("rst_ex_inst", ex_inst, 32'd0);
        check_eq("rst_hazard_cnt", hazard_cnt, 32'd0);
        check_eq("rst_id_ready", 32'(id_ready), 32'd0);
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i * 17);
        m_valid = 0; m_we = 0; m_ld = 0; m_pc = 0; m_inst = 0; m_rs1 = 0; m_rs2 = 0;
        m_rd = 0; m_cnt = 0;
        idle_inputs();
        rst = 1;
        do_reset();

`ifdef FORWARDING_EN
        // EX bypass of an ALU result.
        issue(32'h40, 5'd1, 5'd2, 5'd5, 0); step();
        issue(32'h44, 5'd5, 5'd0, 5'd6, 0); ex_result = 32'h1234; step();
        check_eq("exfwd_rs1", ex_rs1_val, 32'h1234);
        check_eq("exfwd_cnt", hazard_cnt, 32'd0);
        // Load-use: one bubble, then WB bypass.
        issue(32'h48, 5'd1, 5'd0, 5'd7, 1); step();
        issue(32'h4c, 5'd7, 5'd7, 5'd8, 0); step();
        check_eq("lu_bubble", 32'(ex_valid), 32'd0);
        check_eq("lu_cnt", hazard_cnt, 32'd1);
        wb_we = 1; wb_rd = 5'd7; wb_data = 32'hCAFE_F00D; step();
        check_eq("lu_valid", 32'(ex_valid), 32'd1);
        check_eq("lu_rs1", ex_rs1_val, 32'hCAFE_F00D);
        check_eq("lu_rs2", ex_rs2_val, 32'hCAFE_F00D);
        idle_inputs(); step();
`else
        // No bypass: stall until the producer's value is in the register file.
        issue(32'h40, 5'd1, 5'd2, 5'd5, 0); step();
        issue(32'h44, 5'd5, 5'd0, 5'd6, 0); step();
        check_eq("nf_bubble1", 32'(ex_valid), 32'd0);
        wb_we = 1; wb_rd = 5'd5; wb_data = 32'h5555_AAAA; step();
        check_eq("nf_bubble2", 32'(ex_valid), 32'd0);
        wb_we = 0; step();
        check_eq("nf_valid", 32'(ex_valid), 32'd1);
        check_eq("nf_rs1", ex_rs1_val, 32'h5555_AAAA);
        check_eq("nf_cnt", hazard_cnt, 32'd2);
        idle_inputs(); step();
`endif
        // x0 is zero even when WB targets it.
        wb_we = 1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        issue(32'h80, 5'd0, 5'd0, 5'd9, 0); step();
        check_eq("x0_rs1", ex_rs1_val, 32'd0);
        check_eq("x0_rs2", ex_rs2_val, 32'd0);
        idle_inputs(); step();

        // Backpressure then flush.
        do_reset();
        issue(32'h100, 5'd1, 5'd2, 5'd10, 0); step();
        ex_ready = 0;
        issue(32'h104, 5'd3, 5'd4, 5'd11, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_id_ready", 32'(id_ready), 32'd0);
            check_eq("bp_ex_pc", ex_pc, 32'h100);
        end
        flush = 1; step();
        check_eq("fl_ex_valid", 32'(ex_valid), 32'd0);
        check_eq("fl_ex_pc", ex_pc, 32'h100);
        idle_inputs(); step();

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            rst        = ($urandom_range(199) == 0);
            id_valid   = ($urandom_range(3) != 0);
            id_pc      = $urandom;
            id_inst    = $urandom;
            id_rs1     = 5'($urandom_range(7));
            id_rs2     = 5'($urandom_range(7));
            id_rd      = 5'($urandom_range(7));
            id_reg_we  = ($urandom_range(3) != 0);
            id_is_load = ($urandom_range(3) == 0);
            ex_ready   = ($urandom_range(3) != 0);
            ex_result  = $urandom;
            wb_we      = ($urandom_range(1) == 1);
            wb_rd      = 5'($urandom_range(7));
            wb_data    = $urandom;
            flush      = ($urandom_range(15) == 0);
            step();
        end
        rst = 0;
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
